// File: rtl/rsc_receiver.sv
// Hard-decision RSC link checker: re-runs the 8-state constituent encoder trellis,
// counts parity and tail mismatches per block and forwards the systematic stream.
module rsc_receiver #(
  parameter int K_SMALL = 1056,
  parameter int K_LARGE = 6144,
  parameter int CNT_W   = 13,
  parameter int ERR_W   = 16
) (
  input  logic             clk,
  input  logic             aclr_n,
  input  logic             start,
  input  logic             k_sel,
  input  logic             in_valid,
  input  logic             xk,
  input  logic             zk,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             done,
  output logic             term_ok,
  output logic [ERR_W-1:0] err_count,
  output logic [2:0]       state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_TAIL,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   r_klen;
  logic [2:0]         r_q;
  logic [ERR_W-1:0]   r_err;
  logic [ERR_W-1:0]   r_err_out;
  logic               r_tail_mis;
  logic               r_dout;
  logic               r_dout_valid;

  logic               w_in_data;
  logic               w_in_tail;
  logic               w_m0;
  logic               w_s;
  logic               w_p;
  logic               w_zmis;
  logic               w_xmis;
  logic               w_sym;
  logic               w_last_data;
  logic               w_last_tail;
  logic [1:0]         w_inc;
  logic [ERR_W:0]     w_sum;
  logic [ERR_W-1:0]   w_err_nxt;

  assign w_in_data = (r_state == S_DATA);
  assign w_in_tail = (r_state == S_TAIL);

  // Trellis step: tail symbols force the register input to zero, so the
  // expected systematic bit there is the feedback term itself.
  assign w_m0   = r_q[1] ^ r_q[2];
  assign w_s    = w_in_tail ? 1'b0 : (xk ^ w_m0);
  assign w_p    = w_s ^ r_q[0] ^ r_q[2];
  assign w_zmis = (zk != w_p);
  assign w_xmis = w_in_tail && (xk != w_m0);

  // start takes priority: the symbol presented with it is discarded.
  assign w_sym  = in_valid && !start && (w_in_data || w_in_tail);

  // Counter runs 0..K-1 over data and K..K+2 over the tail.
  assign w_last_data = (r_cnt == (r_klen - CNT_W'(1)));
  assign w_last_tail = (r_cnt == (r_klen + CNT_W'(2)));

  assign w_inc     = {1'b0, w_zmis} + {1'b0, w_xmis};
  assign w_sum     = {1'b0, r_err} + {{(ERR_W-1){1'b0}}, w_inc};
  assign w_err_nxt = w_sum[ERR_W] ? '1 : w_sum[ERR_W-1:0];

  always_comb begin
    w_state_nxt = r_state;
    if (start) begin
      w_state_nxt = S_DATA;
    end else begin
      case (r_state)
        S_IDLE: w_state_nxt = S_IDLE;
        S_DATA: if (in_valid && w_last_data) w_state_nxt = S_TAIL;
        S_TAIL: if (in_valid && w_last_tail) w_state_nxt = S_DONE;
        S_DONE: w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!aclr_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!aclr_n) begin
      r_cnt        <= '0;
      r_klen       <= '0;
      r_q          <= '0;
      r_err        <= '0;
      r_err_out    <= '0;
      r_tail_mis   <= 1'b0;
      r_dout       <= 1'b0;
      r_dout_valid <= 1'b0;
    end else begin
      r_dout_valid <= 1'b0;
      if (start) begin
        r_klen     <= k_sel ? CNT_W'(K_LARGE) : CNT_W'(K_SMALL);
        r_cnt      <= '0;
        r_q        <= '0;
        r_err      <= '0;
        r_err_out  <= '0;
        r_tail_mis <= 1'b0;
      end else if (w_sym) begin
        r_q   <= {r_q[1:0], w_s};
        r_cnt <= r_cnt + CNT_W'(1);
        r_err <= w_err_nxt;
        if (w_xmis) begin
          r_tail_mis <= 1'b1;
        end
        if (w_in_data) begin
          r_dout       <= xk;
          r_dout_valid <= 1'b1;
        end
        // Published count includes the final tail symbol's contribution.
        if (w_in_tail && w_last_tail) begin
          r_err_out <= w_err_nxt;
        end
      end
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign busy       = w_in_data || w_in_tail;
  assign done       = (r_state == S_DONE);
  assign term_ok    = done && (r_q == 3'b000) && !r_tail_mis;
  assign err_count  = r_err_out;
  assign state_dbg  = r_q;

endmodule

// File: tb/tb_rsc_receiver.sv
// Scoreboard bench for rsc_receiver: blocks are produced by a reference RSC encoder,
// expected outputs are queued by the driver and checked by an independent monitor.
module tb_rsc_receiver;

  logic        clk;
  logic        aclr_n;
  logic        start;
  logic        k_sel;
  logic        in_valid;
  logic        xk;
  logic        zk;
  logic        dout;
  logic        dout_valid;
  logic        busy;
  logic        done;
  logic        term_ok;
  logic [15:0] err_count;
  logic [2:0]  state_dbg;

  rsc_receiver #(
    .K_SMALL(1056),
    .K_LARGE(6144),
    .CNT_W  (13),
    .ERR_W  (16)
  ) dut (
    .clk       (clk),
    .aclr_n    (aclr_n),
    .start     (start),
    .k_sel     (k_sel),
    .in_valid  (in_valid),
    .xk        (xk),
    .zk        (zk),
    .dout      (dout),
    .dout_valid(dout_valid),
    .busy      (busy),
    .done      (done),
    .term_ok   (term_ok),
    .err_count (err_count),
    .state_dbg (state_dbg)
  );

  typedef struct {
    bit x;
    int cyc;
  } dexp_t;

  typedef struct {
    int err;
    bit tok;
    int cyc;
    int brun;
    int dvn;
  } fexp_t;

  dexp_t dq[$];
  fexp_t fq[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int busy_from = 0;
  int dv_exp    = 0;
  bit in_block  = 0;

  int    brun   = 0;
  int    dv_run = 0;
  dexp_t de;
  fexp_t fe;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Transmit-side constituent encoder: feedback q1^q2, parity s^q0^q2;
  // during termination the systematic bit equals the feedback so s=0.
  function automatic void enc(input bit u, input bit tl, inout bit [2:0] st,
                              output bit x, output bit z);
    bit fb;
    bit s;
    fb = st[1] ^ st[2];
    if (tl) u = fb;
    x  = u;
    s  = u ^ fb;
    z  = s ^ st[0] ^ st[2];
    st = {st[1], st[0], s};
  endfunction

  task automatic drive(input bit st, input bit ks, input bit v, input bit x, input bit z);
    start    = st;
    k_sel    = ks;
    in_valid = v;
    xk       = x;
    zk       = z;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dout"},       dout, 0);
    chk({tag, "_dout_valid"}, dout_valid, 0);
    chk({tag, "_busy"},       busy, 0);
    chk({tag, "_done"},       done, 0);
    chk({tag, "_term_ok"},    term_ok, 0);
    chk({tag, "_err_count"},  err_count, 0);
    chk({tag, "_state_dbg"},  state_dbg, 0);
  endtask

  // mode: 0 all-zero, 1 impulse, 2 random. abort_at / rst_at < 0 disable.
  task automatic send_block(input bit ks, input int mode, input int gap,
                            input int flipz, input int flipt,
                            input int abort_at, input int rst_at);
    int       kk;
    bit [2:0] st;
    bit       u, x, z;
    int       nerr;
    bit       tmis;
    int       last;
    kk   = ks ? 6144 : 1056;
    st   = 3'b000;
    nerr = 0;
    tmis = 0;
    last = 0;
    if (!in_block) begin
      busy_from = cyc;
      dv_exp    = 0;
    end
    in_block = 1;
    drive(1, ks, 1, 1'($urandom), 1'($urandom));
    for (int i = 0; i < kk; i++) begin
      if (i == abort_at) return;
      while (int'($urandom_range(99)) < gap) drive(0, ks, 0, 1'($urandom), 1'($urandom));
      u = (mode == 0) ? 1'b0 : (mode == 1) ? (i == 0) : 1'($urandom);
      enc(u, 1'b0, st, x, z);
      if (i == flipz) begin
        z = ~z;
        nerr++;
      end
      dq.push_back('{x, cyc + 1});
      dv_exp++;
      drive(0, ks, 1, x, z);
    end
    for (int j = 0; j < 3; j++) begin
      while (int'($urandom_range(99)) < gap) drive(0, ks, 0, 1'($urandom), 1'($urandom));
      enc(1'b0, 1'b1, st, x, z);
      if (j == flipt) begin
        x = ~x;
        nerr++;
        tmis = 1;
      end
      if (j == rst_at) begin
        aclr_n = 1'b0;
        drive(0, ks, 1, x, z);
        chk_all_zero("midtail_reset");
        aclr_n   = 1'b1;
        in_block = 0;
        in_valid = 1'b0;
        return;
      end
      last = cyc;
      drive(0, ks, 1, x, z);
    end
    in_valid = 1'b0;
    fq.push_back('{nerr, !tmis, last + 1, last - busy_from, dv_exp});
    in_block = 0;
  endtask

  always @(negedge clk) begin
    if (dout_valid) begin
      chk("dout_expected", dq.size() != 0, 1);
      if (dq.size() != 0) begin
        de = dq.pop_front();
        chk("dout", dout, de.x);
        chk("dout_cycle", cyc, de.cyc);
      end
      dv_run++;
    end
    if (done) begin
      chk("done_expected", fq.size() != 0, 1);
      if (fq.size() != 0) begin
        fe = fq.pop_front();
        chk("err_count", err_count, fe.err);
        chk("term_ok", term_ok, fe.tok);
        chk("done_cycle", cyc, fe.cyc);
        chk("busy_cycles", brun, fe.brun);
        chk("dout_valid_pulses", dv_run, fe.dvn);
      end
      brun   = 0;
      dv_run = 0;
    end else if (busy) begin
      brun++;
    end else begin
      brun   = 0;
      dv_run = 0;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    aclr_n   = 1'b0;
    start    = 1'b0;
    k_sel    = 1'b0;
    in_valid = 1'b1;
    xk       = 1'b1;
    zk       = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    aclr_n   = 1'b1;
    in_valid = 1'b0;
    drive(0, 0, 0, 0, 0);

    // back-to-back blocks also exercise start during the DONE cycle
    send_block(0, 0, 0, -1, -1, -1, -1);
    send_block(0, 1, 0, -1, -1, -1, -1);
    send_block(0, 1, 0, 10, 1, -1, -1);
    repeat (4) drive(0, 0, 0, 0, 0);

    send_block(1, 2, 30, -1, -1, -1, -1);
    repeat (4) drive(0, 0, 0, 0, 0);

    send_block(1, 2, 0, -1, -1, 500, -1);
    send_block(0, 2, 0, -1, -1, -1, -1);
    repeat (4) drive(0, 0, 0, 0, 0);

    send_block(0, 2, 10, -1, -1, -1, 1);
    for (int i = 0; i < 6; i++) drive(0, 0, 1, 1'($urandom), 1'($urandom));
    chk("idle_busy_after_reset", busy, 0);
    chk("idle_state_after_reset", state_dbg, 0);
    send_block(0, 2, 0, 5, -1, -1, -1);
    send_block(0, 2, 20, -1, 2, -1, -1);
    repeat (10) drive(0, 0, 0, 0, 0);

    chk("dout_queue_drained", dq.size(), 0);
    chk("done_queue_drained", fq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
